// File: rtl/clint_irq_sched_if.sv
// Request/acknowledge channel between the interrupt scheduler and the trap sequencer.
// Latency: none (wires only).
// Backpressure: the request is held until the sequencer acks it or the scheduler withdraws it.
//
// Signals (named from the scheduler's point of view):
//   irq_req_o    scheduler -> sequencer  interrupt request, registered
//   irq_cause_o  scheduler -> sequencer  mcause for the pending request
//   irq_ack_i    sequencer -> scheduler  request accepted (1-cycle pulse)
//   mret_i       sequencer -> scheduler  MRET accepted (1-cycle pulse)
interface clint_irq_sched_if;
    logic        irq_req_o;
    logic [31:0] irq_cause_o;
    logic        irq_ack_i;
    logic        mret_i;

    // Scheduler side.
    modport master (
        output irq_req_o,
        output irq_cause_o,
        input  irq_ack_i,
        input  mret_i
    );

    // Trap-sequencer side.
    modport slave (
        input  irq_req_o,
        input  irq_cause_o,
        output irq_ack_i,
        output mret_i
    );
endinterface

// File: rtl/clint_irq_sched.sv
// Machine-level interrupt scheduler: syncs ext IRQ, masks by mie/mstatus.MIE, picks ext>timer>soft.
// Latency: timer/soft -> irq_req_o 1 cycle; ext -> irq_req_o SYNC_STAGES+1 cycles.
// Backpressure: request and cause held stable until irq_ack_i; new requests blocked in service/hold-off.
//
// Ports:
//   clk, rst_n                 core clock, asynchronous active-low reset
//   ext_int_req_i              external IRQ level, asynchronous to clk
//   timer_irq_i, soft_irq_i    timer / software IRQ levels, clk domain
//   csr_mie_i, csr_mstatus_i   mie (bits 11/7/3) and mstatus (bit 3) CSR values
//   trap_if (master)           irq_req_o / irq_cause_o out, irq_ack_i / mret_i in
//   irq_pending_o              {ext,timer,soft} pending after mie masking, combinational
//   sched_busy_o               scheduler is not idle
module clint_irq_sched #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned HOLDOFF_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ext_int_req_i,
    input  logic                     timer_irq_i,
    input  logic                     soft_irq_i,
    input  logic [31:0]              csr_mie_i,
    input  logic [31:0]              csr_mstatus_i,
    clint_irq_sched_if.master        trap_if,
    output logic [2:0]               irq_pending_o,
    output logic                     sched_busy_o
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [31:0] CAUSE_EXT   = 32'h8000_000B;
    localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;
    localparam logic [31:0] CAUSE_SOFT  = 32'h8000_0003;

    localparam int unsigned CNT_W = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
    // The first hold-off cycle is the one right after MRET, so the load value
    // is one less than the window length.
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (HOLDOFF_CYCLES > 0) ? CNT_W'(HOLDOFF_CYCLES - 1) : '0;

    // Source one-hot encoding, same bit order as irq_pending_o.
    localparam logic [2:0] SRC_EXT   = 3'b100;
    localparam logic [2:0] SRC_TIMER = 3'b010;
    localparam logic [2:0] SRC_SOFT  = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2,
        S_HOLDOFF = 2'd3
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                 state_q, state_d;
    logic                   req_q, req_d;
    logic [31:0]            cause_q, cause_d;
    logic [2:0]             src_q, src_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;

    // ------------------------------------------------------------------
    // Source conditioning and arbitration
    // ------------------------------------------------------------------
    logic        ext_sync;
    logic        mstatus_mie;
    logic [2:0]  pending;
    logic        elig;
    logic [2:0]  win_src;
    logic [31:0] win_cause;
    logic        src_still_pending;

    // Only a handful of CSR bits matter here; the rest are deliberately dropped.
    logic unused_csr_bits;
    assign unused_csr_bits = ^{csr_mie_i[31:12], csr_mie_i[10:8], csr_mie_i[6:4],
                               csr_mie_i[2:0], csr_mstatus_i[31:4], csr_mstatus_i[2:0]};

    // Shift register synchronizer; the external level enters at bit 0.
    assign sync_d   = {sync_q[SYNC_STAGES-2:0], ext_int_req_i};
    assign ext_sync = sync_q[SYNC_STAGES-1];

    assign mstatus_mie = csr_mstatus_i[3];
    assign pending     = {ext_sync    & csr_mie_i[11],
                          timer_irq_i & csr_mie_i[7],
                          soft_irq_i  & csr_mie_i[3]};
    assign elig        = (|pending) & mstatus_mie;

    // Fixed priority ext > timer > soft.
    always_comb begin
        win_src   = 3'b000;
        win_cause = 32'h0;
        if (pending[2]) begin
            win_src   = SRC_EXT;
            win_cause = CAUSE_EXT;
        end else if (pending[1]) begin
            win_src   = SRC_TIMER;
            win_cause = CAUSE_TIMER;
        end else if (pending[0]) begin
            win_src   = SRC_SOFT;
            win_cause = CAUSE_SOFT;
        end
    end

    // Withdraw only depends on the source that won originally, not on
    // whatever else might be pending now.
    assign src_still_pending = |(src_q & pending);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cause_d = cause_q;
        src_d   = src_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (elig) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    cause_d = win_cause;
                    src_d   = win_src;
                end
            end

            S_REQ: begin
                // Cause is frozen here: no preemption by later arrivals.
                // Ack is checked first so it wins over a same-cycle withdraw.
                if (trap_if.irq_ack_i) begin
                    state_d = S_SERVICE;
                    req_d   = 1'b0;
                end else if (!src_still_pending || !mstatus_mie) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                end
            end

            S_SERVICE: begin
                // No nesting: the MIE state is not looked at until the trap returns.
                if (trap_if.mret_i) begin
                    if (HOLDOFF_CYCLES > 0) begin
                        state_d = S_HOLDOFF;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_HOLDOFF: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (elig) begin
                    // The window has run out on this edge, so sources are
                    // evaluated here as IDLE would. This keeps the MRET to
                    // next-request latency at HOLDOFF_CYCLES+1.
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    cause_d = win_cause;
                    src_d   = win_src;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            cause_q <= 32'h0;
            src_q   <= 3'b000;
            cnt_q   <= '0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cause_q <= cause_d;
            src_q   <= src_d;
            cnt_q   <= cnt_d;
            sync_q  <= sync_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign trap_if.irq_req_o   = req_q;
    assign trap_if.irq_cause_o = cause_q;
    assign irq_pending_o       = pending;
    assign sched_busy_o        = (state_q != S_IDLE);

endmodule
